// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Purpose  : Holds the PC, fetches one 32-bit instruction at a time from
//            instruction memory (req/ack) and presents it to decode
//            (valid/ready). The next PC is selected by decode and applied
//            when the held instruction is consumed. No speculation.
// Ports    : clk, rst_n                       clock, async active-low reset
//            imem_req/addr/ack/rdata          instruction memory handshake
//            inst_valid/ready, inst, opcode,
//            inst_pc, pc_plus4                decode handshake + held fields
//            next_sel, branch_taken, imm16,
//            target26, rs_value               next-PC selection from decode
//            misaligned                       sticky misaligned JR target
//            fetch_count                      consumed-instruction counter
// Revision : 1.0  initial release
// ============================================================================
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [5:0]  opcode,
  output logic [31:0] inst_pc,
  output logic [31:0] pc_plus4,
  input  logic [1:0]  next_sel,
  input  logic        branch_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  input  logic [31:0] rs_value,
  output logic        misaligned,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      r_state,      w_stateNext;
  logic [31:0] r_pc,         w_pcNext;
  logic        r_imemReq,    w_imemReqNext;
  logic        r_instValid,  w_instValidNext;
  logic [31:0] r_inst,       w_instNext;
  logic [31:0] r_instPc,     w_instPcNext;
  logic        r_misaligned, w_misalignedNext;
  logic [31:0] r_fetchCount, w_fetchCountNext;

  logic [31:0] w_pcPlus4;
  logic [31:0] w_branchOff;
  logic [31:0] w_nextPc;

  // Link value and the base for every PC-relative target.
  assign w_pcPlus4   = r_instPc + 32'd4;
  // Branch offset is in words: sign-extend, then scale by 4.
  assign w_branchOff = {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    w_nextPc = w_pcPlus4;
    case (next_sel)
      2'b01:   w_nextPc = branch_taken ? (w_pcPlus4 + w_branchOff) : w_pcPlus4;
      2'b10:   w_nextPc = {w_pcPlus4[31:28], target26, 2'b00};
      2'b11:   w_nextPc = {rs_value[31:2], 2'b00};
      default: w_nextPc = w_pcPlus4;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= BOOT;
      r_pc         <= RESET_PC;
      r_imemReq    <= 1'b0;
      r_instValid  <= 1'b0;
      r_inst       <= 32'd0;
      r_instPc     <= RESET_PC;
      r_misaligned <= 1'b0;
      r_fetchCount <= 32'd0;
    end else begin
      r_state      <= w_stateNext;
      r_pc         <= w_pcNext;
      r_imemReq    <= w_imemReqNext;
      r_instValid  <= w_instValidNext;
      r_inst       <= w_instNext;
      r_instPc     <= w_instPcNext;
      r_misaligned <= w_misalignedNext;
      r_fetchCount <= w_fetchCountNext;
    end
  end

  always_comb begin
    w_stateNext      = r_state;
    w_pcNext         = r_pc;
    w_imemReqNext    = r_imemReq;
    w_instValidNext  = r_instValid;
    w_instNext       = r_inst;
    w_instPcNext     = r_instPc;
    w_misalignedNext = r_misaligned;
    w_fetchCountNext = r_fetchCount;
    case (r_state)
      BOOT: begin
        w_stateNext   = FETCH;
        w_imemReqNext = 1'b1;
      end
      FETCH: begin
        // inst_ready is deliberately not looked at here.
        if (imem_ack) begin
          w_instNext      = imem_rdata;
          w_instPcNext    = r_pc;
          w_instValidNext = 1'b1;
          w_imemReqNext   = 1'b0;
          w_stateNext     = HOLD;
        end
      end
      HOLD: begin
        // imem_ack is deliberately not looked at here.
        if (inst_ready) begin
          w_pcNext         = w_nextPc;
          w_instValidNext  = 1'b0;
          w_imemReqNext    = 1'b1;
          w_fetchCountNext = r_fetchCount + 32'd1;
          w_stateNext      = FETCH;
          if (next_sel == 2'b11 && rs_value[1:0] != 2'b00) begin
            w_misalignedNext = 1'b1;
          end
        end
      end
      default: begin
        w_stateNext     = BOOT;
        w_imemReqNext   = 1'b0;
        w_instValidNext = 1'b0;
      end
    endcase
  end

  assign imem_req    = r_imemReq;
  assign imem_addr   = r_pc;
  assign inst_valid  = r_instValid;
  assign inst        = r_inst;
  assign opcode      = r_inst[31:26];
  assign inst_pc     = r_instPc;
  assign pc_plus4    = w_pcPlus4;
  assign misaligned  = r_misaligned;
  assign fetch_count = r_fetchCount;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch
// Purpose  : Self-checking bench for instruction_fetch. Directed steps
//            followed by randomized instructions, checked against a
//            reference model of the PC/counter rules kept in the bench.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [5:0]  opcode;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus4;
  logic [1:0]  next_sel;
  logic        branch_taken;
  logic [15:0] imm16;
  logic [25:0] target26;
  logic [31:0] rs_value;
  logic        misaligned;
  logic [31:0] fetch_count;

  instruction_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst         (inst),
    .opcode       (opcode),
    .inst_pc      (inst_pc),
    .pc_plus4     (pc_plus4),
    .next_sel     (next_sel),
    .branch_taken (branch_taken),
    .imm16        (imm16),
    .target26     (target26),
    .rs_value     (rs_value),
    .misaligned   (misaligned),
    .fetch_count  (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;

  // Reference model state
  logic [31:0] expPc;
  logic [31:0] expInst;
  logic [31:0] expInstPc;
  logic [31:0] expCount;
  logic        expMis;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Next PC from the architectural rules, using wide integer arithmetic
  // and reducing modulo 2^32 at the end.
  function automatic logic [31:0] refNext(input logic [31:0] ipc, input logic [1:0] sel,
                                          input logic taken, input logic [15:0] imm,
                                          input logic [25:0] tgt, input logic [31:0] rs);
    longint seqPc;
    longint r;
    seqPc = longint'(ipc) + 4;
    case (sel)
      2'd0:    r = seqPc;
      2'd1:    r = taken ? seqPc + 4 * longint'($signed(imm)) : seqPc;
      2'd2:    r = ((seqPc % 64'h1_0000_0000) / 64'h1000_0000) * 64'h1000_0000 + longint'(tgt) * 4;
      default: r = longint'(rs) - (longint'(rs) % 4);
    endcase
    r = r % 64'h1_0000_0000;
    if (r < 0) r = r + 64'h1_0000_0000;
    return r[31:0];
  endfunction

  task automatic checkHeld(input string tag);
    check({tag, "_valid"}, inst_valid, 1);
    check({tag, "_req"}, imem_req, 0);
    check({tag, "_inst"}, inst, expInst);
    check({tag, "_opcode"}, opcode, expInst >> 26);
    check({tag, "_instpc"}, inst_pc, expInstPc);
    check({tag, "_pcplus4"}, pc_plus4, expInstPc + 32'd4);
    check({tag, "_count"}, fetch_count, expCount);
    check({tag, "_mis"}, misaligned, expMis);
  endtask

  // Entered at a negedge with the DUT in FETCH; leaves at a negedge in HOLD.
  task automatic fetchPhase(input int waitCycles, input logic [31:0] data);
    for (int w = 0; w <= waitCycles; w++) begin
      check("fetch_req", imem_req, 1);
      check("fetch_addr", imem_addr, expPc);
      check("fetch_valid", inst_valid, 0);
      inst_ready = 1'($urandom_range(0, 1));
      imem_ack   = (w == waitCycles);
      imem_rdata = (w == waitCycles) ? data : $urandom();
      @(negedge clk);
    end
    imem_ack   = 1'b0;
    inst_ready = 1'b0;
    expInst    = data;
    expInstPc  = expPc;
    checkHeld("hold");
  endtask

  task automatic stall(input int n);
    for (int s = 0; s < n; s++) begin
      inst_ready = 1'b0;
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom();
      @(negedge clk);
      checkHeld("stall");
    end
    imem_ack = 1'b0;
  endtask

  task automatic consume(input logic [1:0] sel, input logic taken, input logic [15:0] imm,
                         input logic [25:0] tgt, input logic [31:0] rs);
    next_sel     = sel;
    branch_taken = taken;
    imm16        = imm;
    target26     = tgt;
    rs_value     = rs;
    inst_ready   = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    expPc    = refNext(expInstPc, sel, taken, imm, tgt, rs);
    expCount = expCount + 32'd1;
    if (sel == 2'd3 && (rs % 4) != 0) expMis = 1'b1;
    check("cons_valid", inst_valid, 0);
    check("cons_req", imem_req, 1);
    check("cons_addr", imem_addr, expPc);
    check("cons_count", fetch_count, expCount);
    check("cons_mis", misaligned, expMis);
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_req"}, imem_req, 0);
    check({tag, "_valid"}, inst_valid, 0);
    check({tag, "_inst"}, inst, 0);
    check({tag, "_instpc"}, inst_pc, RESET_PC);
    check({tag, "_addr"}, imem_addr, RESET_PC);
    check({tag, "_mis"}, misaligned, 0);
    check({tag, "_count"}, fetch_count, 0);
  endtask

  task automatic modelReset();
    expPc     = RESET_PC;
    expInstPc = RESET_PC;
    expInst   = 32'd0;
    expCount  = 32'd0;
    expMis    = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    imem_ack     = 1'b0;
    imem_rdata   = 32'd0;
    inst_ready   = 1'b0;
    next_sel     = 2'd0;
    branch_taken = 1'b0;
    imm16        = 16'd0;
    target26     = 26'd0;
    rs_value     = 32'd0;
    modelReset();

    // Power-on reset, then release; BOOT holds imem_req low for one cycle.
    repeat (2) @(negedge clk);
    checkReset("por");
    rst_n = 1'b1;
    #1 checkReset("boot");
    @(negedge clk);

    // Zero-wait fetch of 0x20080005 at address 0, sequential consume.
    fetchPhase(0, 32'h2008_0005);
    check("first_opcode", opcode, 32'h08);
    consume(2'd0, 1'b0, 16'd0, 26'd0, 32'd0);

    // Three wait states, four stall cycles.
    fetchPhase(3, $urandom());
    stall(4);
    consume(2'd0, 1'b0, 16'd0, 26'd0, 32'd0);
    fetchPhase(1, $urandom());
    consume(2'd0, 1'b0, 16'd0, 26'd0, 32'd0);
    fetchPhase(0, $urandom());
    consume(2'd0, 1'b0, 16'd0, 26'd0, 32'd0);

    // Taken backward branch at 0x10.
    fetchPhase(2, $urandom());
    check("br_instpc", inst_pc, 32'h0000_0010);
    consume(2'd1, 1'b1, 16'hFFFC, 26'd0, 32'd0);
    check("br_taken_addr", imem_addr, 32'h0000_0004);

    // Into HOLD with five consumed, then an asynchronous reset pulse.
    fetchPhase(0, $urandom());
    check("pre_rst_count", fetch_count, 32'd5);
    #2 rst_n = 1'b0;
    #1 checkReset("midrst");
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    #1 checkReset("reboot");
    @(negedge clk);

    // Restart from RESET_PC, JR to 0x10, untaken branch.
    fetchPhase(1, $urandom());
    consume(2'd3, 1'b0, 16'd0, 26'd0, 32'h0000_0010);
    fetchPhase(0, $urandom());
    consume(2'd1, 1'b0, 16'hFFFC, 26'd0, 32'd0);
    check("br_nt_addr", imem_addr, 32'h0000_0014);

    // Jump within the 0x4xxxxxxx region.
    fetchPhase(0, $urandom());
    consume(2'd3, 1'b0, 16'd0, 26'd0, 32'h3FFF_FFFC);
    fetchPhase(0, $urandom());
    consume(2'd0, 1'b0, 16'd0, 26'd0, 32'd0);
    fetchPhase(0, $urandom());
    check("j_pcplus4", pc_plus4, 32'h4000_0004);
    consume(2'd2, 1'b0, 16'd0, 26'h000_0040, 32'd0);
    check("j_addr", imem_addr, 32'h4000_0100);

    // Misaligned JR sets the sticky flag; then wrap-around at the top.
    fetchPhase(2, $urandom());
    consume(2'd3, 1'b0, 16'd0, 26'd0, 32'h0000_1006);
    check("jr_addr", imem_addr, 32'h0000_1004);
    check("jr_mis", misaligned, 1);
    fetchPhase(0, $urandom());
    consume(2'd3, 1'b0, 16'd0, 26'd0, 32'hFFFF_FFFC);
    fetchPhase(1, $urandom());
    consume(2'd0, 1'b0, 16'd0, 26'd0, 32'd0);
    check("wrap_addr", imem_addr, 32'h0000_0000);
    check("wrap_mis", misaligned, 1);

    // Randomized instruction stream.
    for (int i = 0; i < 40; i++) begin
      fetchPhase($urandom_range(0, 3), $urandom());
      stall($urandom_range(0, 2));
      consume(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 16'($urandom()),
              26'($urandom()), $urandom());
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    nFail++;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
